// File: rtl/rc4_pkg.sv
// RC4 shared types: KSA state encoding, S-array depth and key bundle.
// Used by the key scheduler and its neighbours in the cracking pipeline.
package rc4_pkg;
  localparam int S_DEPTH   = 256;
  localparam int KEY_BYTES = 3;
  localparam int BYTE_W    = 8;

  typedef logic [KEY_BYTES-1:0][BYTE_W-1:0] key_t;

  // bit 4 is busy, bit 3 is finished; low bits tell busy states apart
  typedef enum logic [4:0] {
    IDLE   = 5'b0_0_000,
    DONE   = 5'b0_1_000,
    INIT   = 5'b1_0_000,
    READ_I = 5'b1_0_001,
    WAIT_I = 5'b1_0_010,
    CALC_J = 5'b1_0_011,
    READ_J = 5'b1_0_100,
    WAIT_J = 5'b1_0_101,
    SWAP_I = 5'b1_0_110,
    SWAP_J = 5'b1_0_111
  } ksa_state_t;
endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector shared by the pipeline controllers.
// Output is combinational against the registered previous level.
module edge_detector (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);
  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
endmodule

// File: rtl/ksa_scheduler.sv
// RC4 key-scheduling stage: fills S with identity, then runs the
// KSA swap loop over the S-RAM, pulsing finished when S is ready.
module ksa_scheduler
  import rc4_pkg::*;
#(
  parameter int KEY_LENGTH = 3,
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key,
  input  logic [RAM_WIDTH-1:0]                 q,
  output logic [ADDR_WIDTH-1:0]                address,
  output logic [RAM_WIDTH-1:0]                 data,
  output logic                                 wren,
  output logic                                 busy,
  output logic                                 finished
);
  localparam int KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  localparam logic [RAM_WIDTH-1:0] I_LAST = RAM_WIDTH'(S_DEPTH - 1);
  localparam logic [KW-1:0] K_LAST = KW'(KEY_LENGTH - 1);

  ksa_state_t state_q, state_d;
  logic [RAM_WIDTH-1:0] i_q, i_d;
  logic [RAM_WIDTH-1:0] j_q, j_d;
  logic [RAM_WIDTH-1:0] si_q, si_d;
  logic [RAM_WIDTH-1:0] kbyte;
  logic [KW-1:0] kidx_q, kidx_d;
  logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key_q, key_d;
  logic start_sig;

  edge_detector u_start_edge (
    .clk  (clk),
    .reset(reset),
    .sig  (start),
    .rise (start_sig)
  );

  // kidx 0 selects the MS key byte
  always_comb begin
    kbyte = '0;
    for (int k = 0; k < KEY_LENGTH; k++) begin
      if (kidx_q == KW'(KEY_LENGTH - 1 - k)) kbyte = key_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    kidx_d  = kidx_q;
    key_d   = key_q;
    unique case (state_q)
      IDLE: begin
        if (start_sig) begin
          state_d = INIT;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          key_d   = key;
        end
      end
      INIT: begin
        i_d = i_q + 1'b1;
        if (i_q == I_LAST) state_d = READ_I;
      end
      READ_I: state_d = WAIT_I;
      WAIT_I: state_d = CALC_J;
      CALC_J: begin
        si_d    = q;
        j_d     = j_q + q + kbyte;
        state_d = READ_J;
      end
      READ_J: state_d = WAIT_J;
      WAIT_J: state_d = SWAP_I;
      SWAP_I: state_d = SWAP_J;
      SWAP_J: begin
        if (i_q == I_LAST) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 1'b1;
          kidx_d  = (kidx_q == K_LAST) ? '0 : kidx_q + 1'b1;
          state_d = READ_I;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    address = '0;
    data    = '0;
    wren    = 1'b0;
    unique case (state_q)
      INIT: begin
        address = ADDR_WIDTH'(i_q);
        data    = i_q;
        wren    = 1'b1;
      end
      READ_I, WAIT_I: address = ADDR_WIDTH'(i_q);
      READ_J, WAIT_J: address = ADDR_WIDTH'(j_q);
      SWAP_I: begin
        address = ADDR_WIDTH'(i_q);
        data    = q;
        wren    = 1'b1;
      end
      SWAP_J: begin
        address = ADDR_WIDTH'(j_q);
        data    = si_q;
        wren    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = state_q[4];
  assign finished = state_q[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      kidx_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      kidx_q  <= kidx_d;
      key_q   <= key_d;
    end
  end
endmodule

// File: tb/tb_ksa_scheduler.sv
// Bench for ksa_scheduler: software KSA trace model, S-RAM model
// with two-cycle read latency, per-cycle output comparison.
module tb_ksa_scheduler;
  import rc4_pkg::*;

  localparam int LAST = 2049;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  key_t       key;
  logic [7:0] q;
  logic [7:0] address;
  logic [7:0] data;
  logic       wren;
  logic       busy;
  logic       finished;

  always #5 clk = ~clk;

  ksa_scheduler #(
    .KEY_LENGTH(3),
    .RAM_WIDTH (8),
    .ADDR_WIDTH(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .key     (key),
    .q       (q),
    .address (address),
    .data    (data),
    .wren    (wren),
    .busy    (busy),
    .finished(finished)
  );

  // S-RAM: registered address, registered output
  logic [7:0] mem [256];
  logic [7:0] addr_r;
  always @(posedge clk) begin
    if (wren) mem[address] <= data;
    addr_r <= address;
    q      <= mem[addr_r];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // expected per-cycle trace of a full run, indexed by run cycle
  logic [7:0] e_s  [256];
  bit         e_wr [LAST+1];
  bit         e_av [LAST+1];
  logic [7:0] e_ad [LAST+1];
  logic [7:0] e_dt [LAST+1];

  task automatic build(input key_t k);
    int j;
    int b;
    logic [7:0] t;
    logic [7:0] kb;
    for (int c = 0; c <= LAST; c++) begin
      e_wr[c] = 0; e_av[c] = 0; e_ad[c] = '0; e_dt[c] = '0;
    end
    for (int n = 0; n < 256; n++) begin
      e_wr[n+1] = 1; e_av[n+1] = 1;
      e_ad[n+1] = 8'(n); e_dt[n+1] = 8'(n);
      e_s[n] = 8'(n);
    end
    j = 0;
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0:       kb = k[2];
        1:       kb = k[1];
        default: kb = k[0];
      endcase
      j = (j + int'(e_s[i]) + int'(kb)) % 256;
      b = 257 + 7 * i;
      e_av[b]   = 1; e_ad[b]   = 8'(i);
      e_av[b+1] = 1; e_ad[b+1] = 8'(i);
      e_av[b+3] = 1; e_ad[b+3] = 8'(j);
      e_av[b+4] = 1; e_ad[b+4] = 8'(j);
      e_wr[b+5] = 1; e_av[b+5] = 1;
      e_ad[b+5] = 8'(i); e_dt[b+5] = e_s[j];
      e_wr[b+6] = 1; e_av[b+6] = 1;
      e_ad[b+6] = 8'(j); e_dt[b+6] = e_s[i];
      t = e_s[i]; e_s[i] = e_s[j]; e_s[j] = t;
    end
  endtask

  int cyc = 0;
  int t0 = -1000000;
  int stop_rc = -1;
  bit mon_en = 0;
  int fin_cnt = 0;
  int fin_rc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int rc;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        rc = cyc - t0;
        if (finished) begin
          fin_cnt++;
          fin_rc = rc;
        end
        if (rc >= 0 && rc <= stop_rc) begin
          chk($sformatf("busy@%0d", rc), 32'(busy),
              32'(rc >= 1 && rc <= 2048));
          chk($sformatf("finished@%0d", rc), 32'(finished),
              32'(rc == LAST));
          chk($sformatf("wren@%0d", rc), 32'(wren), 32'(e_wr[rc]));
          if (e_av[rc])
            chk($sformatf("address@%0d", rc), 32'(address),
                32'(e_ad[rc]));
          if (e_wr[rc])
            chk($sformatf("data@%0d", rc), 32'(data), 32'(e_dt[rc]));
        end else begin
          chk("idle_busy", 32'(busy), 32'd0);
          chk("idle_finished", 32'(finished), 32'd0);
          chk("idle_wren", 32'(wren), 32'd0);
        end
      end
    end
  end

  task automatic to_rc(input int n);
    while (cyc - t0 < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input key_t k);
    start = 1'b0;
    @(posedge clk);
    #1;
    build(k);
    key     = k;
    start   = 1'b1;
    t0      = cyc;
    stop_rc = LAST;
    fin_cnt = 0;
    fin_rc  = -1;
  endtask

  task automatic chk_mem(input string nm);
    int bad;
    bad = 0;
    for (int n = 0; n < 256; n++) if (mem[n] !== e_s[n]) bad++;
    chk(nm, 32'(bad), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    key   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // reset mid-INIT
    go(24'h000000);
    to_rc(100);
    reset   = 1'b1;
    stop_rc = 100;
    @(posedge clk);
    #1;
    chk("abort_address", 32'(address), 32'd0);
    chk("abort_data", 32'(data), 32'd0);
    chk("abort_wren", 32'(wren), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // all-zero key, full run after abort
    go(24'h000000);
    chk("model_init_first", {e_ad[1], e_dt[1]}, 32'h0000);
    chk("model_init_last", {e_ad[256], e_dt[256]}, 32'hFFFF);
    to_rc(LAST + 1);
    chk("k0_fin_rc", 32'(fin_rc), 32'(LAST));
    chk("k0_fin_cnt", 32'(fin_cnt), 32'd1);
    chk_mem("k0_final_S");

    // first swaps, hand-derived
    go(24'h010203);
    chk("model_i0_rdj", 32'(e_ad[260]), 32'h01);
    chk("model_i0_swi", {e_ad[262], e_dt[262]}, 32'h0001);
    chk("model_i0_swj", {e_ad[263], e_dt[263]}, 32'h0100);
    chk("model_i1_rdj", 32'(e_ad[267]), 32'h03);
    chk("model_i1_swi", {e_ad[269], e_dt[269]}, 32'h0103);
    chk("model_i1_swj", {e_ad[270], e_dt[270]}, 32'h0300);
    to_rc(LAST + 1);
    chk("k010203_fin_rc", 32'(fin_rc), 32'(LAST));
    chk_mem("k010203_final_S");

    // start held high: exactly one run
    go(24'hFFFFFF);
    to_rc(3000);
    chk("hold_fin_cnt", 32'(fin_cnt), 32'd1);
    chk("hold_fin_rc", 32'(fin_rc), 32'(LAST));
    chk_mem("kFFFFFF_final_S");

    // start toggles while busy, key changes after latch
    go(24'h1A2B3C);
    to_rc(2);
    start = 1'b0;
    to_rc(5);
    key = 24'h5A5A5A;
    to_rc(300);
    start = 1'b1;
    to_rc(301);
    start = 1'b0;
    to_rc(700);
    start = 1'b1;
    to_rc(1500);
    start = 1'b0;
    to_rc(LAST + 1);
    chk("toggle_fin_cnt", 32'(fin_cnt), 32'd1);
    chk("toggle_fin_rc", 32'(fin_rc), 32'(LAST));
    chk_mem("k1A2B3C_final_S");
    repeat (5) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
